// File: rtl/usb_max10_pkg.sv
// rtl/usb_max10_pkg.sv - shared types and constants for the MAX10 FIFO-bus responder
package usb_max10_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [1:0] USB_ADDR_DATA    = 2'd0;
    localparam logic [1:0] USB_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] USB_ADDR_SCRATCH = 2'd2;
    localparam logic [1:0] USB_ADDR_RSVD    = 2'd3;

    localparam int STAT_TX_AVAIL = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_OVF      = 2;
    localparam int STAT_UDF      = 3;
    localparam int STAT_PROTO    = 4;

    // Sticky bits are kept as a 3-bit vector that maps onto status[4:2].
    localparam int STK_OVF   = STAT_OVF - 2;
    localparam int STK_UDF   = STAT_UDF - 2;
    localparam int STK_PROTO = STAT_PROTO - 2;

    function automatic logic [7:0] status_byte(input logic tx_empty, input logic rx_full,
                                               input logic [2:0] sticky);
        return {3'b000, sticky, rx_full, !tx_empty};
    endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// rtl/usb_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count and synchronous flush
module usb_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Flags come from the pre-update pointers, so push+pop together leave count unchanged.
    assign do_push  = push & !full;
    assign do_pop   = pop & !empty;
    assign pop_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/usb_max10_fifo_responder.sv
// rtl/usb_max10_fifo_responder.sv - MAX10 async FIFO-bus responder; optional USB_FIFO_LOOPBACK_EN adds RX->TX loopback
module usb_max10_fifo_responder
    import usb_max10_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       usb_resetn,
    input  logic [1:0] usb_addr,
    input  logic [7:0] usb_data_i,
    output logic [7:0] usb_data_o,
    output logic       usb_data_oe,
    input  logic       usb_rdn,
    input  logic       usb_wrn,
    input  logic       usb_oen,
    output logic       usb_empty,
    output logic       usb_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
`ifdef USB_FIFO_LOOPBACK_EN
    ,
    input  logic       cfg_loopback
`endif
);
    localparam int              CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(1 << DEPTH_LOG2);

    logic                   bus_arst_n, bus_flush;
    logic [1:0]             bus_rst_q, bus_rst_d;
    logic [SYNC_STAGES-1:0] rdn_sync_q, rdn_sync_d, wrn_sync_q, wrn_sync_d;
    logic [SYNC_STAGES-1:0] oen_sync_q, oen_sync_d, vld_q, vld_d;
    logic                   rdn_prev_q, rdn_prev_d, wrn_prev_q, wrn_prev_d;
    logic                   rdn_s, wrn_s, oen_s, samp_ok, rd_fall, wr_fall;
    state_e                 state_q, state_d;
    logic [1:0]             addr_q, addr_d;
    logic [7:0]             data_o_q, data_o_d, scratch_q, scratch_d;
    logic [2:0]             sticky_q, sticky_d;
    logic                   oe_q, oe_d, usb_empty_q, usb_empty_d, usb_full_q, usb_full_d;
    logic                   rx_push, rx_pop, rx_full, rx_empty;
    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]             rx_head, tx_head, tx_push_data;
    logic [CW-1:0]          rx_count, tx_count;

    // Bus reset asserts asynchronously and releases synchronously; it only clears bus-side state.
    assign bus_arst_n = resetn & usb_resetn;
    assign bus_rst_d  = {bus_rst_q[0], 1'b1};
    assign bus_flush  = !bus_rst_q[1];

    always_ff @(posedge clk or negedge bus_arst_n) begin
        if (!bus_arst_n) bus_rst_q <= '0;
        else             bus_rst_q <= bus_rst_d;
    end

    assign rdn_s   = rdn_sync_q[SYNC_STAGES-1];
    assign wrn_s   = wrn_sync_q[SYNC_STAGES-1];
    assign oen_s   = oen_sync_q[SYNC_STAGES-1];
    // vld_q tracks when the synchronisers hold real pin samples, so a strobe held low through reset never looks like an edge.
    assign samp_ok = vld_q[SYNC_STAGES-1];
    assign rd_fall = rdn_prev_q & !rdn_s & samp_ok;
    assign wr_fall = wrn_prev_q & !wrn_s & samp_ok;

`ifdef USB_FIFO_LOOPBACK_EN
    logic lb_move;
    assign lb_move      = cfg_loopback & !rx_empty & !tx_full;
    assign rx_valid     = !rx_empty & !cfg_loopback;
    assign tx_ready     = !tx_full & !cfg_loopback;
    assign rx_pop       = lb_move | (rx_valid & rx_ready);
    assign tx_push      = lb_move | (tx_valid & tx_ready);
    assign tx_push_data = cfg_loopback ? rx_head : tx_data;
`else
    assign rx_valid     = !rx_empty;
    assign tx_ready     = !tx_full;
    assign rx_pop       = rx_valid & rx_ready;
    assign tx_push      = tx_valid & tx_ready;
    assign tx_push_data = tx_data;
`endif

    assign rx_data     = rx_head;
    assign usb_data_o  = data_o_q;
    assign usb_data_oe = oe_q;
    assign usb_empty   = usb_empty_q;
    assign usb_full    = usb_full_q;

    always_comb begin
        rdn_sync_d  = {rdn_sync_q[SYNC_STAGES-2:0], usb_rdn};
        wrn_sync_d  = {wrn_sync_q[SYNC_STAGES-2:0], usb_wrn};
        oen_sync_d  = {oen_sync_q[SYNC_STAGES-2:0], usb_oen};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        rdn_prev_d  = samp_ok & rdn_s;
        wrn_prev_d  = samp_ok & wrn_s;
        state_d     = state_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        scratch_d   = scratch_q;
        sticky_d    = sticky_q;
        oe_d        = (state_q == ST_READ) & !oen_s;
        usb_empty_d = (tx_count == '0);
        usb_full_d  = (rx_count == FULL_CNT);
        rx_push     = 1'b0;
        tx_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((rd_fall || wr_fall) && !rdn_s && !wrn_s) begin
                    state_d             = ST_ERR;
                    sticky_d[STK_PROTO] = 1'b1;
                end else if (rd_fall) begin
                    state_d = ST_READ;
                    addr_d  = usb_addr;
                    case (usb_addr)
                        USB_ADDR_DATA: begin
                            if (tx_empty) begin
                                data_o_d          = 8'h00;
                                sticky_d[STK_UDF] = 1'b1;
                            end else begin
                                data_o_d = tx_head;
                                tx_pop   = 1'b1;
                            end
                        end
                        USB_ADDR_STATUS:  data_o_d = status_byte(tx_empty, rx_full, sticky_q);
                        USB_ADDR_SCRATCH: data_o_d = scratch_q;
                        default:          data_o_d = 8'h00;
                    endcase
                end else if (wr_fall) begin
                    state_d = ST_WRITE;
                    case (usb_addr)
                        USB_ADDR_DATA: begin
                            if (rx_full) sticky_d[STK_OVF] = 1'b1;
                            else         rx_push = 1'b1;
                        end
                        USB_ADDR_SCRATCH: scratch_d = usb_data_i;
                        default: ;
                    endcase
                end
            end
            ST_READ: begin
                if (rdn_s) begin
                    state_d = ST_IDLE;
                    if (addr_q == USB_ADDR_STATUS) sticky_d = '0;
                end
            end
            ST_WRITE: if (wrn_s) state_d = ST_IDLE;
            default:  if (rdn_s && wrn_s) state_d = ST_IDLE;
        endcase

        if (bus_flush) begin
            rdn_sync_d  = '1;
            wrn_sync_d  = '1;
            oen_sync_d  = '1;
            vld_d       = '0;
            rdn_prev_d  = 1'b0;
            wrn_prev_d  = 1'b0;
            state_d     = ST_IDLE;
            addr_d      = '0;
            data_o_d    = '0;
            scratch_d   = '0;
            sticky_d    = '0;
            oe_d        = 1'b0;
            usb_empty_d = 1'b1;
            usb_full_d  = 1'b0;
            rx_push     = 1'b0;
            tx_pop      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdn_sync_q  <= '1;
            wrn_sync_q  <= '1;
            oen_sync_q  <= '1;
            vld_q       <= '0;
            rdn_prev_q  <= 1'b0;
            wrn_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_o_q    <= '0;
            scratch_q   <= '0;
            sticky_q    <= '0;
            oe_q        <= 1'b0;
            usb_empty_q <= 1'b1;
            usb_full_q  <= 1'b0;
        end else begin
            rdn_sync_q  <= rdn_sync_d;
            wrn_sync_q  <= wrn_sync_d;
            oen_sync_q  <= oen_sync_d;
            vld_q       <= vld_d;
            rdn_prev_q  <= rdn_prev_d;
            wrn_prev_q  <= wrn_prev_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            scratch_q   <= scratch_d;
            sticky_q    <= sticky_d;
            oe_q        <= oe_d;
            usb_empty_q <= usb_empty_d;
            usb_full_q  <= usb_full_d;
        end
    end

    usb_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (bus_flush),
        .push      (rx_push),
        .push_data (usb_data_i),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    usb_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (bus_flush),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

endmodule

// File: tb/tb_usb_max10_fifo_responder.sv
// tb/tb_usb_max10_fifo_responder.sv - directed self-checking bench for usb_max10_fifo_responder
module tb_usb_max10_fifo_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       usb_resetn = 1'b1;
    logic [1:0] usb_addr = 2'd0;
    logic [7:0] usb_data_i = 8'h00;
    logic [7:0] usb_data_o;
    logic       usb_data_oe;
    logic       usb_rdn = 1'b1;
    logic       usb_wrn = 1'b1;
    logic       usb_oen = 1'b1;
    logic       usb_empty, usb_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
`ifdef USB_FIFO_LOOPBACK_EN
    logic       cfg_loopback = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    usb_max10_fifo_responder #(.DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .usb_resetn  (usb_resetn),
        .usb_addr    (usb_addr),
        .usb_data_i  (usb_data_i),
        .usb_data_o  (usb_data_o),
        .usb_data_oe (usb_data_oe),
        .usb_rdn     (usb_rdn),
        .usb_wrn     (usb_wrn),
        .usb_oen     (usb_oen),
        .usb_empty   (usb_empty),
        .usb_full    (usb_full),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
`ifdef USB_FIFO_LOOPBACK_EN
        ,
        .cfg_loopback(cfg_loopback)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        usb_addr = a;
        usb_data_i = d;
        usb_wrn = 1'b0;
        repeat (6) @(negedge clk);
        usb_wrn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        usb_addr = a;
        usb_rdn = 1'b0;
        usb_oen = 1'b0;
        repeat (5) @(negedge clk);
        d  = usb_data_o;
        oe = usb_data_oe;
        usb_rdn = 1'b1;
        usb_oen = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_push(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop1();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       oe;

        // reset state
        repeat (2) @(negedge clk);
        chk8("rst_data_o", usb_data_o, 8'h00);
        chk1("rst_oe", usb_data_oe, 1'b0);
        chk1("rst_empty", usb_empty, 1'b1);
        chk1("rst_full", usb_full, 1'b0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        resetn = 1'b1;
        repeat (6) @(negedge clk);

        // 1: two bus writes to the data FIFO
        bus_write(2'd0, 8'hA5);
        bus_write(2'd0, 8'h3C);
        chk1("t1_rx_valid", rx_valid, 1'b1);
        chk8("t1_rx_data0", rx_data, 8'hA5);
        chk1("t1_full", usb_full, 1'b0);
        rx_pop1();
        chk8("t1_rx_data1", rx_data, 8'h3C);
        rx_pop1();
        chk1("t1_rx_drained", rx_valid, 1'b0);

        // 2: FPGA byte read by host
        tx_push(8'h11);
        @(negedge clk);
        chk1("t2_empty_pre", usb_empty, 1'b0);
        bus_read(2'd0, rd, oe);
        chk8("t2_rd_data", rd, 8'h11);
        chk1("t2_rd_oe", oe, 1'b1);
        chk1("t2_empty_post", usb_empty, 1'b1);
        chk1("t2_oe_released", usb_data_oe, 1'b0);

        // 3: fill RX, overflow, sticky clear on status read
        for (int i = 0; i < 17; i++) begin
            bus_write(2'd0, 8'h20 + 8'(i));
            if (i == 14) chk1("t3_full_at15", usb_full, 1'b0);
            if (i == 15) chk1("t3_full_at16", usb_full, 1'b1);
        end
        bus_read(2'd1, rd, oe);
        chk8("t3_status1", rd, 8'h06);
        bus_read(2'd1, rd, oe);
        chk8("t3_status2", rd, 8'h02);
        for (int i = 0; i < 16; i++) begin
            chk8("t3_drain", rx_data, 8'h20 + 8'(i));
            rx_ready = 1'b1;
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk1("t3_17th_dropped", rx_valid, 1'b0);
        @(negedge clk);
        chk1("t3_full_clear", usb_full, 1'b0);

        // 4: underflow read
        bus_read(2'd0, rd, oe);
        chk8("t4_udf_data", rd, 8'h00);
        bus_read(2'd1, rd, oe);
        chk8("t4_status", rd, 8'h08);

        // scratch and reserved address
        bus_write(2'd2, 8'h5C);
        bus_read(2'd2, rd, oe);
        chk8("scratch_rd", rd, 8'h5C);
        bus_write(2'd3, 8'hFF);
        bus_read(2'd3, rd, oe);
        chk8("rsvd_rd", rd, 8'h00);

        // 5: rdn and wrn low together
        tx_push(8'h66);
        @(negedge clk);
        usb_addr = 2'd0;
        usb_data_i = 8'h99;
        usb_rdn = 1'b0;
        usb_wrn = 1'b0;
        usb_oen = 1'b0;
        repeat (6) @(negedge clk);
        chk1("t5_oe", usb_data_oe, 1'b0);
        chk1("t5_no_push", rx_valid, 1'b0);
        chk1("t5_no_pop", usb_empty, 1'b0);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        usb_oen = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(2'd1, rd, oe);
        chk8("t5_status", rd, 8'h11);
        bus_read(2'd0, rd, oe);
        chk8("t5_tx_byte", rd, 8'h66);

        // 6: resetn pulse in the middle of a read
        tx_push(8'h77);
        @(negedge clk);
        usb_addr = 2'd0;
        usb_rdn = 1'b0;
        usb_oen = 1'b0;
        repeat (5) @(negedge clk);
        chk1("t6_oe_before", usb_data_oe, 1'b1);
        chk8("t6_data_before", usb_data_o, 8'h77);
        resetn = 1'b0;
        #1;
        chk1("t6_oe_async", usb_data_oe, 1'b0);
        chk1("t6_empty", usb_empty, 1'b1);
        chk1("t6_rx_valid", rx_valid, 1'b0);
        chk8("t6_data_o", usb_data_o, 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        tx_push(8'h99);
        repeat (8) @(negedge clk);
        chk1("t6_no_spurious_oe", usb_data_oe, 1'b0);
        chk1("t6_no_spurious_pop", usb_empty, 1'b0);
        usb_rdn = 1'b1;
        usb_oen = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(2'd0, rd, oe);
        chk8("t6_after_reset_rd", rd, 8'h99);

        // bus-side reset clears scratch
        bus_write(2'd2, 8'hAB);
        @(negedge clk);
        usb_resetn = 1'b0;
        repeat (3) @(negedge clk);
        usb_resetn = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(2'd2, rd, oe);
        chk8("usb_reset_scratch", rd, 8'h00);

`ifdef USB_FIFO_LOOPBACK_EN
        // 7: internal loopback
        cfg_loopback = 1'b1;
        bus_write(2'd0, 8'h5A);
        repeat (3) @(negedge clk);
        chk1("t7_rx_valid", rx_valid, 1'b0);
        bus_read(2'd0, rd, oe);
        chk8("t7_loop_data", rd, 8'h5A);
        cfg_loopback = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
